pipe_flow_ctrl: RTL and testbench
=================================

# pipe_flow_ctrl

Pipeline flow controller for the five-stage MIPS core. It generates the freeze and flush controls for the IF/D and D/E pipeline registers, and the exception PC-select code. It detects load-use hazards and mult/div busy hazards, and tracks the mult/div unit latency with an internal counter. It also sequences interrupt entry and ERET return through a small state machine, so the stage registers and PC mux are driven from one place.

## Interface
Parameters:
- MULT_CYCLES, default 5: number of cycles md_busy stays high after a multiply starts (legal range 1..15).
- DIV_CYCLES, default 10: number of cycles md_busy stays high after a divide starts (legal range 1..15).

Ports:
- clk, input, 1: the single clock; all state updates on its rising edge.
- reset, input, 1: asynchronous, active-high.
- rs_d, input, 5: rs field of the instruction in D.
- rt_d, input, 5: rt field of the instruction in D.
- use_rs_d, input, 1: the D instruction reads rs.
- use_rt_d, input, 1: the D instruction reads rt.
- wa_e, input, 5: destination register of the instruction in E.
- load_e, input, 1: the E instruction is a load.
- md_start_e, input, 1: a mult or div is issuing from E this cycle.
- md_div_e, input, 1: qualifies md_start_e; 1 = div, 0 = mult.
- md_use_d, input, 1: the D instruction is mult, div, mfhi, mflo, mthi or mtlo.
- irq_req, input, 1: level interrupt request from CP0.
- eret_d, input, 1: the D instruction is ERET.
- stall_d, output, 1: freezes the PC and IF/D.
- flush_fd, output, 1: clears IF/D.
- flush_e, output, 1: inserts a bubble into D/E.
- pc_sel_exc, output, 2: PC source. 00 = normal, 01 = handler 0x00004180, 10 = EPC.
- md_busy, output, 1: the mult/div unit is computing.

## Operation
- State machine states: RUN, TAKE, HANDLER, RET. Reset state is RUN.
- Transitions:
  - RUN: irq_req=1 at an edge -> TAKE.
  - TAKE -> HANDLER unconditionally.
  - HANDLER: eret_d=1 and stall_d=0 at an edge -> RET. irq_req is ignored in HANDLER.
  - RET -> RUN unconditionally.
  - eret_d in RUN has no effect.
- Load-use hazard: lu = load_e & (wa_e≠0) & ((use_rs_d & rs_d==wa_e) | (use_rt_d & rt_d==wa_e)).
- Mult/div hazard: mdh = md_use_d & (md_busy | md_start_e).
- stall_d = (lu | mdh) in RUN and HANDLER; stall_d = 0 in TAKE and RET.
- flush_e = stall_d | (state==TAKE).
- flush_fd = 1 in TAKE and RET, otherwise 0.
- pc_sel_exc = 01 in TAKE, 10 in RET, otherwise 00.
- Mult/div counter (4 bits):
  - On md_start_e with count==0, load MULT_CYCLES or DIV_CYCLES according to md_div_e.
  - Otherwise decrement while nonzero.
  - md_busy = (count≠0).
  - md_start_e while busy is ignored; the counter keeps running.
  - The counter runs independently of the state machine, including during TAKE, HANDLER and RET.
- All outputs are forced to 0 while reset is high.

## Timing
- stall_d, flush_e and hazard detection are combinational, in the same cycle as the inputs.
- Interrupt entry: irq_req sampled at edge N -> TAKE during cycle N+1 (flush_fd=1, flush_e=1, pc_sel_exc=01) -> HANDLER from edge N+2.
- Return: eret_d with no stall at edge N -> RET during cycle N+1 (flush_fd=1, pc_sel_exc=10) -> RUN from edge N+2.
- ERET blocked by a hazard stays in D with stall_d=1; RET is entered only on the first unstalled edge.
- Mult/div latency: md_start_e at edge N -> md_busy high for cycles N+1 .. N+MULT_CYCLES (or N+DIV_CYCLES), then low.
- A D-stage md instruction stalls in the start cycle and in every busy cycle, and proceeds in the first cycle with md_busy=0.
- Simultaneous events:
  - irq_req and a hazard in RUN: stall_d follows the hazard in that cycle; TAKE overrides it the next cycle.
  - irq_req and eret_d in HANDLER: RET is taken and irq is ignored.
- Reset asserted mid-operation, in any state or count: immediate return to RUN, count 0, all outputs 0.
- After reset is released, the first edge evaluates normally.

## Test plan
- Load-use hazard: load_e=1, wa_e=8, rs_d=8, use_rs_d=1 -> stall_d=1 and flush_e=1 that cycle; with wa_e=0 -> stall_d=0.
- Divide busy: md_start_e=1, md_div_e=1 at edge 0 -> md_busy=1 for cycles 1..10, 0 at cycle 11. A D-stage mflo held from cycle 0 gets stall_d=1 through cycle 10 and 0 at cycle 11.
- Interrupt entry: irq_req=1 in RUN -> next cycle flush_fd=1, flush_e=1, pc_sel_exc=01, stall_d=0; following cycle state is HANDLER and pc_sel_exc=00. irq_req held high causes no second TAKE.
- Return under stall: eret_d=1 in HANDLER together with a load-use hazard -> stall_d=1 and no RET. Hazard clears -> next cycle flush_fd=1, pc_sel_exc=10; then RUN.
- Stray ERET: eret_d=1 in RUN -> pc_sel_exc stays 00 and flush_fd stays 0.
- Reset mid-operation: reset pulsed asynchronously mid-cycle during TAKE with count=7 -> all outputs 0 immediately. After release: state RUN, md_busy=0.

Source files
------------

// File: rtl/pipe_flow_ctrl.sv
// Pipeline flow controller: load-use / mult-div hazard stalls, mult/div latency
// counter, and the interrupt-entry / ERET sequencing that drives the PC mux.
module pipe_flow_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rs_d,
    input  logic [4:0] rt_d,
    input  logic       use_rs_d,
    input  logic       use_rt_d,
    input  logic [4:0] wa_e,
    input  logic       load_e,
    input  logic       md_start_e,
    input  logic       md_div_e,
    input  logic       md_use_d,
    input  logic       irq_req,
    input  logic       eret_d,
    output logic       stall_d,
    output logic       flush_fd,
    output logic       flush_e,
    output logic [1:0] pc_sel_exc,
    output logic       md_busy
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        TAKE    = 2'd1,
        HANDLER = 2'd2,
        RET     = 2'd3
    } state_t;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    state_t     state;
    logic [3:0] count;
    logic       lu;
    logic       mdh;
    logic       stall_ok;

    always_comb begin
        lu = load_e && (wa_e != '0) &&
             ((use_rs_d && (rs_d == wa_e)) || (use_rt_d && (rt_d == wa_e)));
        mdh      = md_use_d && (md_busy || md_start_e);
        stall_ok = (state == RUN) || (state == HANDLER);
    end

    // Reset gating keeps the combinational outputs at 0 while reset is high.
    assign md_busy = (count != '0);
    assign stall_d = ~reset & stall_ok & (lu | mdh);
    assign flush_e = stall_d | (~reset & (state == TAKE));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (md_start_e && (count == '0)) begin
            count <= md_div_e ? DIV_LOAD : MULT_LOAD;
        end else if (count != '0) begin
            count <= count - 4'd1;
        end
    end

    // flush_fd / pc_sel_exc are registered together with the state they decode.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= RUN;
            flush_fd   <= 1'b0;
            pc_sel_exc <= 2'b00;
        end else begin
            case (state)
                RUN: begin
                    if (irq_req) begin
                        state      <= TAKE;
                        flush_fd   <= 1'b1;
                        pc_sel_exc <= 2'b01;
                    end
                end
                TAKE: begin
                    state      <= HANDLER;
                    flush_fd   <= 1'b0;
                    pc_sel_exc <= 2'b00;
                end
                HANDLER: begin
                    if (eret_d && !stall_d) begin
                        state      <= RET;
                        flush_fd   <= 1'b1;
                        pc_sel_exc <= 2'b10;
                    end
                end
                RET: begin
                    state      <= RUN;
                    flush_fd   <= 1'b0;
                    pc_sel_exc <= 2'b00;
                end
                default: begin
                    state      <= RUN;
                    flush_fd   <= 1'b0;
                    pc_sel_exc <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// Self-checking bench for pipe_flow_ctrl: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a model.
module tb_pipe_flow_ctrl;

    localparam int MC = 5;
    localparam int DC = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rs_d, rt_d, wa_e;
    logic       use_rs_d, use_rt_d, load_e, md_start_e, md_div_e, md_use_d;
    logic       irq_req, eret_d;
    logic       stall_d, flush_fd, flush_e, md_busy;
    logic [1:0] pc_sel_exc;

    int checks = 0;
    int errors = 0;
    bit model_on = 1'b0;

    pipe_flow_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .rs_d(rs_d), .rt_d(rt_d),
        .use_rs_d(use_rs_d), .use_rt_d(use_rt_d), .wa_e(wa_e), .load_e(load_e),
        .md_start_e(md_start_e), .md_div_e(md_div_e), .md_use_d(md_use_d),
        .irq_req(irq_req), .eret_d(eret_d), .stall_d(stall_d),
        .flush_fd(flush_fd), .flush_e(flush_e), .pc_sel_exc(pc_sel_exc),
        .md_busy(md_busy)
    );

    always #5 clk = ~clk;

    // Model: mode is a phase name, busy_left is remaining mult/div cycles.
    string mode = "RUN";
    int    busy_left = 0;

    function automatic bit m_hazard();
        bit lu, mdh;
        lu  = load_e && (wa_e != 0) &&
              ((use_rs_d && rs_d == wa_e) || (use_rt_d && rt_d == wa_e));
        mdh = md_use_d && ((busy_left > 0) || md_start_e);
        return lu || mdh;
    endfunction

    function automatic bit m_stall();
        return !reset && (mode == "RUN" || mode == "HANDLER") && m_hazard();
    endfunction

    always @(posedge reset) begin
        mode = "RUN";
        busy_left = 0;
    end

    always @(posedge clk) begin
        if (reset) begin
            mode = "RUN";
            busy_left = 0;
        end else begin
            bit st;
            st = m_stall();
            if (mode == "RUN") begin
                if (irq_req) mode = "TAKE";
            end else if (mode == "TAKE") mode = "HANDLER";
            else if (mode == "HANDLER") begin
                if (eret_d && !st) mode = "RET";
            end else mode = "RUN";
            if (md_start_e && busy_left == 0) busy_left = md_div_e ? DC : MC;
            else if (busy_left > 0) busy_left--;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (model_on) begin
            bit st;
            st = m_stall();
            chk("m_stall_d", stall_d, st);
            chk("m_flush_e", flush_e, st || (!reset && mode == "TAKE"));
            chk("m_flush_fd", flush_fd, !reset && (mode == "TAKE" || mode == "RET"));
            chk("m_pc_sel", pc_sel_exc,
                reset ? 0 : (mode == "TAKE" ? 1 : (mode == "RET" ? 2 : 0)));
            chk("m_md_busy", md_busy, !reset && busy_left > 0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        rs_d = 0; rt_d = 0; wa_e = 0; use_rs_d = 0; use_rt_d = 0; load_e = 0;
        md_start_e = 0; md_div_e = 0; md_use_d = 0; irq_req = 0; eret_d = 0;
    endtask

    initial begin
        clear_in();
        reset = 1'b1;
        #1;
        chk("rst_stall", stall_d, 0);
        chk("rst_flush_fd", flush_fd, 0);
        chk("rst_flush_e", flush_e, 0);
        chk("rst_pc_sel", pc_sel_exc, 0);
        chk("rst_busy", md_busy, 0);
        #11 reset = 1'b0;
        model_on = 1'b1;
        step();

        // load-use
        load_e = 1; wa_e = 8; rs_d = 8; use_rs_d = 1;
        #1;
        chk("lu_stall", stall_d, 1);
        chk("lu_flush_e", flush_e, 1);
        wa_e = 0; rs_d = 0;
        #1;
        chk("lu_r0_stall", stall_d, 0);
        clear_in();
        step();

        // divide busy with mflo held in D
        md_start_e = 1; md_div_e = 1; md_use_d = 1;
        #1;
        chk("div_c0_stall", stall_d, 1);
        step();
        md_start_e = 0; md_div_e = 0;
        for (int k = 1; k <= 11; k++) begin
            #1;
            chk("div_busy", md_busy, (k <= 10) ? 1 : 0);
            chk("div_stall", stall_d, (k <= 10) ? 1 : 0);
            step();
        end
        clear_in();

        // interrupt entry, irq held
        irq_req = 1;
        step();
        chk("take_flush_fd", flush_fd, 1);
        chk("take_flush_e", flush_e, 1);
        chk("take_pc_sel", pc_sel_exc, 1);
        chk("take_stall", stall_d, 0);
        step();
        chk("hdl_pc_sel", pc_sel_exc, 0);
        chk("hdl_flush_fd", flush_fd, 0);
        step();
        chk("hdl_no_retake", pc_sel_exc, 0);
        irq_req = 0;

        // ERET blocked by load-use, then released
        eret_d = 1; load_e = 1; wa_e = 5; rt_d = 5; use_rt_d = 1;
        #1;
        chk("eret_blk_stall", stall_d, 1);
        step();
        chk("eret_blk_pc", pc_sel_exc, 0);
        load_e = 0;
        #1;
        chk("eret_free_stall", stall_d, 0);
        step();
        chk("ret_pc_sel", pc_sel_exc, 2);
        chk("ret_flush_fd", flush_fd, 1);
        clear_in();
        step();
        chk("ret_run_pc", pc_sel_exc, 0);

        // stray ERET in RUN
        eret_d = 1;
        step();
        chk("stray_pc", pc_sel_exc, 0);
        chk("stray_flush_fd", flush_fd, 0);
        clear_in();
        step();

        // reset mid-TAKE with count 7
        md_start_e = 1; md_div_e = 1;
        step();
        md_start_e = 0; md_div_e = 0;
        step();
        step();
        irq_req = 1;
        step();
        chk("pre_rst_pc", pc_sel_exc, 1);
        chk("pre_rst_busy", md_busy, 1);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_flush_fd", flush_fd, 0);
        chk("mid_rst_flush_e", flush_e, 0);
        chk("mid_rst_pc", pc_sel_exc, 0);
        chk("mid_rst_busy", md_busy, 0);
        chk("mid_rst_stall", stall_d, 0);
        #2 reset = 1'b0;
        irq_req = 0;
        step();
        chk("post_rst_pc", pc_sel_exc, 0);
        chk("post_rst_busy", md_busy, 0);
        chk("post_rst_flush_fd", flush_fd, 0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rs_d       = 5'($urandom_range(0, 3));
            rt_d       = 5'($urandom_range(0, 3));
            wa_e       = 5'($urandom_range(0, 3));
            use_rs_d   = 1'($urandom_range(0, 1));
            use_rt_d   = 1'($urandom_range(0, 1));
            load_e     = ($urandom_range(0, 3) == 0);
            md_start_e = ($urandom_range(0, 5) == 0);
            md_div_e   = 1'($urandom_range(0, 1));
            md_use_d   = ($urandom_range(0, 3) == 0);
            irq_req    = ($urandom_range(0, 15) == 0);
            eret_d     = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 499) == 0) begin
                #1 reset = 1'b1;
                #1 reset = 1'b0;
            end
            step();
        end

        model_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
